character_drawer: RTL



---
 rtl/character_drawer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/character_drawer.sv
// character_drawer: redraws the player sprite on the 160x120 VGA adapter
// whenever the character state code changes, then pulses DoneDrawing.
// Optional feature macro: CHARDRAW_ERASE_EN (erase old sprite before drawing).
//
// state | meaning
// INIT  | draw sprite at code 0 after reset, no erase
// IDLE  | wait for a valid code that differs from the last drawn one
// ERASE | raster the sprite at the last location in background colour
// DRAW  | raster the sprite at the target location in sprite colour
// DONE  | one-cycle DoneDrawing pulse
module character_drawer #(
  parameter int          X_BASE        = 16,
  parameter int          LANE_PITCH    = 40,
  parameter int          Y_TOP         = 100,
  parameter int          SPRITE_W      = 8,
  parameter int          SPRITE_H      = 8,
  parameter logic [2:0]  SPRITE_COLOUR = 3'b010,
  parameter logic [2:0]  BG_COLOUR     = 3'b000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] CurrState,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       DoneDrawing
);

  localparam int XW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int YW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [XW-1:0] XMAX = XW'(SPRITE_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(SPRITE_H - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [3:0]    last_q;
  logic [3:0]    tgt_q;
  logic [XW-1:0] xo_q;
  logic [YW-1:0] yo_q;
  logic [7:0]    x_q;
  logic [6:0]    y_q;
  logic [2:0]    colour_q;
  logic          plot_q;
  logic          done_q;

  logic [XW-1:0] xo_d;
  logic [YW-1:0] yo_d;
  logic          last_px;
  logic          change;

  // Left edge of the sprite for a lane or in-between (lower) lane code.
  function automatic logic [7:0] base_x(input logic [3:0] code);
    int bx;
    if (code < 4'd4) bx = X_BASE + int'(code) * LANE_PITCH;
    else             bx = X_BASE + ((int'(code) - 4) / 2) * LANE_PITCH + LANE_PITCH / 2;
    return 8'(bx);
  endfunction

  // Next raster offset (row-major) and end-of-sprite detection.
  always_comb begin
    xo_d    = xo_q + 1'b1;
    yo_d    = yo_q;
    if (xo_q == XMAX) begin
      xo_d = '0;
      yo_d = yo_q + 1'b1;
    end
    last_px = (xo_q == XMAX) && (yo_q == YMAX);
    change  = (CurrState <= 4'd9) && (CurrState != last_q);
  end

  // Sequencer with registered pixel outputs; each state emits the pixel
  // visible in the following cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= S_INIT;
      last_q   <= '0;
      tgt_q    <= '0;
      xo_q     <= '0;
      yo_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          tgt_q    <= '0;
          xo_q     <= '0;
          yo_q     <= '0;
          x_q      <= base_x(4'd0);
          y_q      <= 7'(Y_TOP);
          colour_q <= SPRITE_COLOUR;
          plot_q   <= 1'b1;
          state_q  <= S_DRAW;
        end
        S_IDLE: begin
          plot_q <= 1'b0;
          if (change) begin
            tgt_q  <= CurrState;
            xo_q   <= '0;
            yo_q   <= '0;
            y_q    <= 7'(Y_TOP);
            plot_q <= 1'b1;
`ifdef CHARDRAW_ERASE_EN
            x_q      <= base_x(last_q);
            colour_q <= BG_COLOUR;
            state_q  <= S_ERASE;
`else
            x_q      <= base_x(CurrState);
            colour_q <= SPRITE_COLOUR;
            state_q  <= S_DRAW;
`endif
          end
        end
`ifdef CHARDRAW_ERASE_EN
        S_ERASE: begin
          if (last_px) begin
            xo_q     <= '0;
            yo_q     <= '0;
            x_q      <= base_x(tgt_q);
            y_q      <= 7'(Y_TOP);
            colour_q <= SPRITE_COLOUR;
            state_q  <= S_DRAW;
          end else begin
            xo_q <= xo_d;
            yo_q <= yo_d;
            x_q  <= base_x(last_q) + 8'(xo_d);
            y_q  <= 7'(Y_TOP) + 7'(yo_d);
          end
        end
`endif
        S_DRAW: begin
          if (last_px) begin
            last_q  <= tgt_q;
            plot_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            xo_q <= xo_d;
            yo_q <= yo_d;
            x_q  <= base_x(tgt_q) + 8'(xo_d);
            y_q  <= 7'(Y_TOP) + 7'(yo_d);
          end
        end
        S_DONE: begin
          colour_q <= BG_COLOUR;
          plot_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;
  assign DoneDrawing = done_q;

endmodule
